link_constraint_solver: RTL and testbench

Sequential distance-constraint engine for the Verlet rope. It accepts the positions of two linked nodes and computes the corrected positions that are driven back into each node's x_fix_constraint / y_fix_constraint inputs during fix_constraint_state. It is the producer side of the node fix-constraint interface. One multiplier is time-shared across a fixed-latency FSM. Correction uses the linearised rule k = (d² − L²)/(4L²), so no divider and no square root are needed.

---
 rtl/link_pkg.sv | 24 ++
 rtl/fxp_mul.sv | 17 +
 rtl/link_constraint_solver.sv | 141 ++++++++++++++
 tb/tb_link_constraint_solver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared fixed-point types, limits and FSM encoding for the rope link solver.
package link_pkg;

  localparam int FRAC_BITS = 12;
  localparam int FXP_W     = 32;

  typedef logic signed [FXP_W-1:0] fxp_t;

  localparam fxp_t FIX_ONE  = 32'sh0000_1000;
  localparam fxp_t CLAMP_HI = 32'sh0000_0400;
  localparam fxp_t CLAMP_LO = -32'sh0000_0400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIFF,
    S_SQX,
    S_SQY,
    S_ERR,
    S_CX,
    S_CY,
    S_DONE
  } state_t;

endpackage

// File: rtl/fxp_mul.sv
// Combinational Q20.12 signed multiply: full 64-bit product, arithmetic shift, truncate.
module fxp_mul
  import link_pkg::*;
(
  input  fxp_t a_i,
  input  fxp_t b_i,
  output fxp_t p_o
);

  logic signed [2*FXP_W-1:0] full;

  always_comb begin
    full = a_i * b_i;
    p_o  = fxp_t'(full >>> FRAC_BITS);
  end

endmodule

// File: rtl/link_constraint_solver.sv
// Linearised distance-constraint solver for one rope link, one shared multiplier.
// Optional k clamping to [-0.25, +0.25] is enabled by defining LINK_CLAMP_EN.
module link_constraint_solver
  import link_pkg::*;
#(
  parameter logic [31:0] REST_LEN_SQ = 32'h0000_1000,
  parameter logic [31:0] INV_4L2     = 32'h0000_0400,
  parameter logic [31:0] TOL         = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        a_pinned,
  input  logic [31:0] ax,
  input  logic [31:0] ay,
  input  logic [31:0] bx,
  input  logic [31:0] by,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] fix_ax,
  output logic [31:0] fix_ay,
  output logic [31:0] fix_bx,
  output logic [31:0] fix_by
);

  state_t state_q;
  fxp_t   ax_q, ay_q, bx_q, by_q;
  fxp_t   dx_q, dy_q, p_q, k_q, cx_q;
  fxp_t   fix_ax_q, fix_ay_q, fix_bx_q, fix_by_q;
  logic   pin_q;
  logic   resp_valid_q;

  fxp_t   mul_a_d, mul_b_d, mul_p;
  fxp_t   e_d, k_d;
  logic   dead_d;

  fxp_mul u_mul (
    .a_i(mul_a_d),
    .b_i(mul_b_d),
    .p_o(mul_p)
  );

  // p_q holds dx^2 after SQX and the full d^2 after SQY.
  always_comb begin
    e_d     = p_q - fxp_t'(REST_LEN_SQ);
    dead_d  = (e_d <= fxp_t'(TOL)) && (e_d >= -fxp_t'(TOL));
    mul_a_d = '0;
    mul_b_d = '0;
    case (state_q)
      S_SQX: begin mul_a_d = dx_q; mul_b_d = dx_q;                 end
      S_SQY: begin mul_a_d = dy_q; mul_b_d = dy_q;                 end
      S_ERR: begin mul_a_d = e_d;  mul_b_d = fxp_t'(INV_4L2);      end
      S_CX:  begin mul_a_d = k_q;  mul_b_d = dx_q;                 end
      S_CY:  begin mul_a_d = k_q;  mul_b_d = dy_q;                 end
      default: ;
    endcase

    k_d = dead_d ? '0 : mul_p;
    // A pinned node cannot share the correction, so B gets twice the step.
    if (pin_q) k_d = k_d <<< 1;
`ifdef LINK_CLAMP_EN
    if (k_d > CLAMP_HI)      k_d = CLAMP_HI;
    else if (k_d < CLAMP_LO) k_d = CLAMP_LO;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ax_q         <= '0;
      ay_q         <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      pin_q        <= 1'b0;
      dx_q         <= '0;
      dy_q         <= '0;
      p_q          <= '0;
      k_q          <= '0;
      cx_q         <= '0;
      fix_ax_q     <= '0;
      fix_ay_q     <= '0;
      fix_bx_q     <= '0;
      fix_by_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          ax_q    <= ax;
          ay_q    <= ay;
          bx_q    <= bx;
          by_q    <= by;
          pin_q   <= a_pinned;
          state_q <= S_DIFF;
        end
        S_DIFF: begin
          dx_q    <= bx_q - ax_q;
          dy_q    <= by_q - ay_q;
          state_q <= S_SQX;
        end
        S_SQX: begin
          p_q     <= mul_p;
          state_q <= S_SQY;
        end
        S_SQY: begin
          p_q     <= p_q + mul_p;
          state_q <= S_ERR;
        end
        S_ERR: begin
          k_q     <= k_d;
          state_q <= S_CX;
        end
        S_CX: begin
          cx_q    <= mul_p;
          state_q <= S_CY;
        end
        S_CY: begin
          fix_ax_q     <= pin_q ? ax_q : ax_q + cx_q;
          fix_ay_q     <= pin_q ? ay_q : ay_q + mul_p;
          fix_bx_q     <= bx_q - cx_q;
          fix_by_q     <= by_q - mul_p;
          resp_valid_q <= 1'b1;
          state_q      <= S_DONE;
        end
        S_DONE: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign fix_ax     = fix_ax_q;
  assign fix_ay     = fix_ay_q;
  assign fix_bx     = fix_bx_q;
  assign fix_by     = fix_by_q;

endmodule

// File: tb/tb_link_constraint_solver.sv
// Self-checking bench for link_constraint_solver: vector table, scoreboard queue, corner sequences.
module tb_link_constraint_solver;

  typedef struct {
    logic        pin;
    logic [31:0] ax, ay, bx, by;
    logic [31:0] fax, fay, fbx, fby;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        a_pinned = 1'b0;
  logic [31:0] ax = '0, ay = '0, bx = '0, by = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] fix_ax, fix_ay, fix_bx, fix_by;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  link_constraint_solver dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .a_pinned(a_pinned),
    .ax(ax), .ay(ay), .bx(bx), .by(by),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .fix_ax(fix_ax), .fix_ay(fix_ay), .fix_bx(fix_bx), .fix_by(fix_by)
  );

  function automatic vec_t mk(logic p, logic [31:0] a0, a1, b0, b1, f0, f1, f2, f3);
    vec_t v;
    v.pin = p; v.ax = a0; v.ay = a1; v.bx = b0; v.by = b1;
    v.fax = f0; v.fay = f1; v.fbx = f2; v.fby = f3;
    return v;
  endfunction

  function automatic logic [31:0] qmul(logic [31:0] p, logic [31:0] q);
    longint prod;
    prod = longint'($signed(p)) * longint'($signed(q));
    return prod[43:12];
  endfunction

  // Reference arithmetic for randomly generated vectors.
  function automatic vec_t model(logic p, logic [31:0] a0, a1, b0, b1);
    logic [31:0] dx, dy, d2, e, k, cx, cy;
    dx = b0 - a0;
    dy = b1 - a1;
    d2 = qmul(dx, dx) + qmul(dy, dy);
    e  = d2 - 32'h1000;
    k  = ($signed(e) <= 8 && $signed(e) >= -8) ? 32'h0 : qmul(e, 32'h400);
    if (p) k = k << 1;
`ifdef LINK_CLAMP_EN
    if ($signed(k) > 32'sh400) k = 32'h400;
    else if ($signed(k) < -32'sh400) k = 32'hFFFF_FC00;
`endif
    cx = qmul(k, dx);
    cy = qmul(k, dy);
    return mk(p, a0, a1, b0, b1, p ? a0 : a0 + cx, p ? a1 : a1 + cy, b0 - cx, b1 - cy);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic accept(input vec_t v);
    int n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    a_pinned = v.pin; ax = v.ax; ay = v.ay; bx = v.bx; by = v.by;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(v);
  endtask

  // Counts edges including the accepting one; the response must appear on the seventh.
  task automatic wait_resp(string nm);
    int edges = 1;
    while (!resp_valid && edges < 20) begin @(posedge clk); #1; edges++; end
    check({nm, "_latency"}, edges, 32'd7);
  endtask

  task automatic compare_out(string nm);
    vec_t e;
    if (exp_q.size() == 0) begin
      check({nm, "_scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({nm, "_fix_ax"}, fix_ax, e.fax);
    check({nm, "_fix_ay"}, fix_ay, e.fay);
    check({nm, "_fix_bx"}, fix_bx, e.fbx);
    check({nm, "_fix_by"}, fix_by, e.fby);
    $display("txn %s: pin=%0b a=(%h,%h) b=(%h,%h) -> fix_a=(%h,%h) fix_b=(%h,%h)",
             nm, e.pin, e.ax, e.ay, e.bx, e.by, fix_ax, fix_ay, fix_bx, fix_by);
  endtask

  task automatic handshake(string nm);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({nm, "_resp_valid_drop"}, {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v, string nm);
    accept(v);
    wait_resp(nm);
    compare_out(nm);
    handshake(nm);
  endtask

  initial begin
    vec_t v1, v2;
    int n;

    tbl.push_back(mk(0, 32'h0, 32'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h1000));
`ifdef LINK_CLAMP_EN
    tbl.push_back(mk(0, 32'h0, 32'h0, 32'h0, 32'h2000, 32'h0, 32'h0800, 32'h0, 32'h1800));
    tbl.push_back(mk(1, 32'h0, 32'h0, 32'h0, 32'h1400, 32'h0, 32'h0, 32'h0, 32'h0F00));
`else
    tbl.push_back(mk(0, 32'h0, 32'h0, 32'h0, 32'h2000, 32'h0, 32'h1800, 32'h0, 32'h0800));
    tbl.push_back(mk(1, 32'h0, 32'h0, 32'h0, 32'h1400, 32'h0, 32'h0, 32'h0, 32'h0E60));
`endif
    tbl.push_back(mk(0, 32'h0, 32'h0, 32'h0, 32'h1004, 32'h0, 32'h0, 32'h0, 32'h1004));
    tbl.push_back(mk(0, 32'h0, 32'h0, 32'h1000, 32'h1000, 32'h400, 32'h400, 32'hC00, 32'hC00));
    tbl.push_back(mk(0, 32'h1000, 32'h0, 32'h1800, 32'h0, 32'hE80, 32'h0, 32'h1980, 32'h0));
    tbl.push_back(mk(1, 32'h3000, 32'hFFFF_E000, 32'h3000, 32'hFFFF_E000,
                     32'h3000, 32'hFFFF_E000, 32'h3000, 32'hFFFF_E000));
    for (int i = 0; i < 4; i++)
      tbl.push_back(model($urandom_range(0, 1),
                          $urandom_range(0, 32'h3000) - 32'h1800, $urandom_range(0, 32'h3000) - 32'h1800,
                          $urandom_range(0, 32'h3000) - 32'h1800, $urandom_range(0, 32'h3000) - 32'h1800));

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset_fix_ax", fix_ax, 32'h0);
    check("reset_fix_by", fix_by, 32'h0);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: result held while the next request waits, accepted only after return to idle.
    v1 = tbl[1];
    v2 = tbl[4];
    accept(v1);
    wait_resp("bp");
    a_pinned = v2.pin; ax = v2.ax; ay = v2.ay; bx = v2.bx; by = v2.by;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_resp_valid_held", {31'b0, resp_valid}, 32'd1);
      check("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
      check("bp_fix_ay_stable", fix_ay, v1.fay);
      check("bp_fix_by_stable", fix_by, v1.fby);
    end
    compare_out("bp_first");
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_idle_after_handshake", {31'b0, req_ready}, 32'd1);
    check("bp_resp_valid_low", {31'b0, resp_valid}, 32'd0);
    check("bp_fix_ay_kept", fix_ay, v1.fay);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_second_accepted", {31'b0, req_ready}, 32'd0);
    exp_q.push_back(v2);
    wait_resp("bp_second");
    compare_out("bp_second");
    handshake("bp_second");

    // Abort in SQY: previous fix values are non-zero, reset must clear them.
    accept(tbl[2]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_async_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_async_fix_ax", fix_ax, 32'h0);
    check("rst_async_fix_ay", fix_ay, 32'h0);
    check("rst_async_fix_bx", fix_bx, 32'h0);
    check("rst_async_fix_by", fix_by, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    n = 0;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("rst_no_stale_resp", {31'b0, resp_valid}, 32'd0);
    run_vec(tbl[1], "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
